// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one data-memory port between the load buffer and committed stores.
// Stores normally win; a load that keeps losing is granted once its starvation
// count reaches STARVE_LIMIT. Granted loads travel down a fixed-latency tag
// pipeline. When a load reaches the end, its read data and ROB tag are put on
// the CDB. A flush squashes every load still in flight.
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 2,
  parameter int ROB_IX_WIDTH = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    flush_in,
  input  logic                    ld_valid_in,
  input  logic [31:0]             ld_addr_in,
  input  logic [ROB_IX_WIDTH-1:0] ld_rob_ix_in,
  output logic                    ld_ready_out,
  input  logic                    st_valid_in,
  input  logic [31:0]             st_addr_in,
  input  logic [31:0]             st_data_in,
  output logic                    st_ready_out,
  output logic                    mem_en_out,
  output logic                    mem_we_out,
  output logic [31:0]             mem_addr_out,
  output logic [31:0]             mem_wdata_out,
  input  logic [31:0]             mem_rdata_in,
  output logic                    cdb_valid_out,
  output logic signed [31:0]      cdb_data_out,
  output logic [ROB_IX_WIDTH-1:0] cdb_rob_ix_out
);

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  logic                    ld_grant;
  logic                    st_grant;
  logic [2:0]              starve_cnt_q, starve_cnt_d;
  logic [MEM_LATENCY-1:0]  stage_vld_q, stage_vld_d;
  logic [ROB_IX_WIDTH-1:0] stage_ix_q [MEM_LATENCY];
  logic [ROB_IX_WIDTH-1:0] stage_ix_d [MEM_LATENCY];
  logic                    cdb_valid_q, cdb_valid_d;
  logic [31:0]             cdb_data_q, cdb_data_d;
  logic [ROB_IX_WIDTH-1:0] cdb_ix_q, cdb_ix_d;

  // Arbitration: store priority, starvation override, flush blocks loads.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    ld_grant = 1'b0;
    st_grant = 1'b0;
    if (!rst_in) begin
      if (flush_in) begin
        st_grant = st_valid_in;
      end else if (ld_valid_in && st_valid_in) begin
        if (starve_cnt_q == STARVE_MAX) ld_grant = 1'b1;
        else                            st_grant = 1'b1;
      end else begin
        ld_grant = ld_valid_in;
        st_grant = st_valid_in;
      end
    end
  end

  // Starvation counter: counts losses of a waiting load and saturates at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!ld_valid_in || ld_grant) begin
      starve_cnt_d = '0;
    end else if (st_grant && starve_cnt_q != STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + 3'd1;
    end
  end

  // Memory port driven directly from the grant.
  always_comb begin
    mem_en_out    = ld_grant | st_grant;
    mem_we_out    = st_grant;
    mem_addr_out  = '0;
    mem_wdata_out = '0;
    if (st_grant) begin
      mem_addr_out  = st_addr_in;
      mem_wdata_out = st_data_in;
    end else if (ld_grant) begin
      mem_addr_out = ld_addr_in;
    end
  end

  assign ld_ready_out = ld_grant;
  assign st_ready_out = st_grant;

  // Load tag pipeline shift and CDB capture at the last stage.
  always_comb begin
    stage_vld_d = '0;
    stage_ix_d  = stage_ix_q;
    cdb_valid_d = 1'b0;
    cdb_data_d  = cdb_data_q;
    cdb_ix_d    = cdb_ix_q;
    if (!flush_in) begin
      stage_vld_d[0] = ld_grant;
      stage_ix_d[0]  = ld_rob_ix_in;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        stage_vld_d[i] = stage_vld_q[i-1];
        stage_ix_d[i]  = stage_ix_q[i-1];
      end
      if (stage_vld_q[MEM_LATENCY-1]) begin
        cdb_valid_d = 1'b1;
        cdb_data_d  = mem_rdata_in;
        cdb_ix_d    = stage_ix_q[MEM_LATENCY-1];
      end
    end
  end

  // Control state and CDB registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    // NOTE: state is updated with non-blocking assignments so that every
    // register samples the pre-edge value of every other register.
    if (rst_in) begin
      starve_cnt_q <= '0;
      stage_vld_q  <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_data_q   <= '0;
      cdb_ix_q     <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      stage_vld_q  <= stage_vld_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_data_q   <= cdb_data_d;
      cdb_ix_q     <= cdb_ix_d;
    end
  end

  // Stage tags only.
  always_ff @(posedge clk_in) begin
    // NOTE: the tag array is left out of reset. A tag is only read when its
    // stage valid bit is set, and the valid bits are reset.
    stage_ix_q <= stage_ix_d;
  end

  assign cdb_valid_out  = cdb_valid_q;
  assign cdb_data_out   = cdb_data_q;
  assign cdb_rob_ix_out = cdb_ix_q;

endmodule
